pipeline_hazard_ctrl: RTL and testbench

Pipeline controller sitting beside the decode stage of the 5-stage core (IF, ID, EX, MEM, WB).
- Holds a shadow copy of the destination-register information in flight in EX, MEM and WB.
- Decides load-use stalls, IF/ID flushes on decode-resolved control transfers, and operand forwarding selects for Op1/Op2.
- Keeps stall and flush performance counters.

---
 rtl/hazard_pkg.sv | 38 +++
 rtl/hazard_fwd_sel.sv | 27 ++
 rtl/pipeline_hazard_ctrl.sv | 126 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the decode-stage hazard controller: forwarding and
// next-PC encodings, FSM states and the shadow pipeline entry.
package hazard_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned FWD_W = 2;
    localparam int unsigned PCS_W = 2;

    // Operand source select
    localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
    localparam logic [FWD_W-1:0] FWD_EX  = 2'b01;
    localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;
    localparam logic [FWD_W-1:0] FWD_WB  = 2'b11;

    // Sequential next-PC; every other PC_Src value is a control transfer
    localparam logic [PCS_W-1:0] PCS_SEQ = 2'b00;

    typedef enum logic {
        StRun,
        StStall
    } hz_state_e;

    // Destination info of one in-flight instruction
    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] rd;
        logic             regw;
        logic             ld;
    } shadow_t;

    localparam shadow_t SHADOW_INVALID = '0;

    // A source only matters when it is read and is not R0
    function automatic logic src_used(input logic use_bit, input logic [REG_W-1:0] rs);
        return use_bit && (rs != '0);
    endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Youngest-match forwarding select for a single operand.
module hazard_fwd_sel
    import hazard_pkg::*;
(
    input  logic             used,
    input  logic [REG_W-1:0] rs,
    input  shadow_t          e,
    input  shadow_t          m,
    input  shadow_t          w,
    output logic [FWD_W-1:0] fwd
);

    // EX wins over MEM over WB; a load in EX has no result yet, so it is skipped
    always_comb begin
        fwd = FWD_RF;
        if (used) begin
            if (e.v && e.regw && !e.ld && (e.rd == rs)) begin
                fwd = FWD_EX;
            end else if (m.v && m.regw && (m.rd == rs)) begin
                fwd = FWD_MEM;
            end else if (w.v && w.regw && (w.rd == rs)) begin
                fwd = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Decode-side hazard controller: load-use stalls, IF/ID flush on control
// transfers, operand forwarding selects and stall/flush performance counters.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned LOAD_USE_STALLS = 1,
    parameter int unsigned CNT_W           = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec_valid,
    input  logic [REG_W-1:0] dec_Rs1,
    input  logic [REG_W-1:0] dec_Rs2,
    input  logic             dec_use1,
    input  logic             dec_use2,
    input  logic [REG_W-1:0] dec_Rd,
    input  logic             dec_RegW,
    input  logic             dec_mem_R,
    input  logic [PCS_W-1:0] PC_Src,
    output logic             stall_F,
    output logic             stall_D,
    output logic             bubble_E,
    output logic             flush_D,
    output logic [FWD_W-1:0] fwdA,
    output logic [FWD_W-1:0] fwdB,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] STALL_LOAD = 2'(LOAD_USE_STALLS - 1);

    shadow_t   e_q, m_q, w_q;
    shadow_t   dec_entry;
    hz_state_e state_q;
    logic [1:0] cnt_q;
    logic      used1, used2;
    logic      lu_hit;
    logic      stall;

    // Decode-side hazard terms; a stall always overrides a flush
    always_comb begin
        used1     = dec_valid && src_used(dec_use1, dec_Rs1);
        used2     = dec_valid && src_used(dec_use2, dec_Rs2);
        lu_hit    = e_q.v && e_q.ld && e_q.regw &&
                    ((used1 && (e_q.rd == dec_Rs1)) || (used2 && (e_q.rd == dec_Rs2)));
        stall     = (state_q == StStall) || lu_hit;
        stall_F   = stall;
        stall_D   = stall;
        bubble_E  = stall;
        flush_D   = dec_valid && (PC_Src != PCS_SEQ) && !stall;
        dec_entry = '{v: 1'b1, rd: dec_Rd, regw: dec_RegW, ld: dec_mem_R};
    end

    hazard_fwd_sel u_fwd_a (
        .used (used1),
        .rs   (dec_Rs1),
        .e    (e_q),
        .m    (m_q),
        .w    (w_q),
        .fwd  (fwdA)
    );

    hazard_fwd_sel u_fwd_b (
        .used (used2),
        .rs   (dec_Rs2),
        .e    (e_q),
        .m    (m_q),
        .w    (w_q),
        .fwd  (fwdB)
    );

    // Shadow copy of the EX/MEM/WB destination info
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_q <= SHADOW_INVALID;
            m_q <= SHADOW_INVALID;
            w_q <= SHADOW_INVALID;
        end else begin
            w_q <= m_q;
            m_q <= e_q;
            e_q <= (dec_valid && !stall) ? dec_entry : SHADOW_INVALID;
        end
    end

    // Stall FSM; in StStall cnt_q is the number of stall cycles still owed,
    // the current one included, so a hit yields LOAD_USE_STALLS bubbles in total
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StRun;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (lu_hit) begin
                        cnt_q <= STALL_LOAD;
                        if (LOAD_USE_STALLS > 1) begin
                            state_q <= StStall;
                        end
                    end
                end
                StStall: begin
                    cnt_q <= cnt_q - 2'd1;
                    if (cnt_q <= 2'd1) begin
                        state_q <= StRun;
                    end
                end
                default: begin
                    state_q <= StRun;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Performance counters, wrapping naturally at 2^CNT_W
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            stall_cnt <= stall_cnt + CNT_W'(bubble_E);
            flush_cnt <= flush_cnt + CNT_W'(flush_D);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (1 and 3 load-use bubbles, the
// first with narrow counters to exercise wrap) share stimulus and are checked
// against an in-bench pipeline model, directed vectors and corner sequences.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned CW_A = 3;
    localparam int unsigned CW_B = 32;

    logic clk = 1'b0;
    logic rst;
    logic dec_valid, dec_use1, dec_use2, dec_RegW, dec_mem_R;
    logic [4:0] dec_Rs1, dec_Rs2, dec_Rd;
    logic [1:0] PC_Src;

    logic sf_a, sd_a, be_a, fl_a, sf_b, sd_b, be_b, fl_b;
    logic [1:0] fa_a, fb_a, fa_b, fb_b;
    logic [CW_A-1:0] sc_a, fc_a;
    logic [CW_B-1:0] sc_b, fc_b;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.LOAD_USE_STALLS(1), .CNT_W(CW_A)) dut_a (
        .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_Rs1(dec_Rs1), .dec_Rs2(dec_Rs2),
        .dec_use1(dec_use1), .dec_use2(dec_use2), .dec_Rd(dec_Rd), .dec_RegW(dec_RegW),
        .dec_mem_R(dec_mem_R), .PC_Src(PC_Src), .stall_F(sf_a), .stall_D(sd_a),
        .bubble_E(be_a), .flush_D(fl_a), .fwdA(fa_a), .fwdB(fb_a),
        .stall_cnt(sc_a), .flush_cnt(fc_a)
    );

    pipeline_hazard_ctrl #(.LOAD_USE_STALLS(3), .CNT_W(CW_B)) dut_b (
        .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_Rs1(dec_Rs1), .dec_Rs2(dec_Rs2),
        .dec_use1(dec_use1), .dec_use2(dec_use2), .dec_Rd(dec_Rd), .dec_RegW(dec_RegW),
        .dec_mem_R(dec_mem_R), .PC_Src(PC_Src), .stall_F(sf_b), .stall_D(sd_b),
        .bubble_E(be_b), .flush_D(fl_b), .fwdA(fa_b), .fwdB(fb_b),
        .stall_cnt(sc_b), .flush_cnt(fc_b)
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic v; logic [4:0] rd; logic regw; logic ld;
    } ent_t;

    ent_t pipe [2][3];           // [instance][0=EX,1=MEM,2=WB]
    int remain [2];              // stall cycles still owed after a hit
    longint unsigned scnt [2];
    longint unsigned fcnt [2];
    int lus [2] = '{1, 3};

    function automatic logic m_used(input logic u, input logic [4:0] r);
        return u && (r != 5'd0);
    endfunction

    function automatic logic m_stall(input int d);
        if (remain[d] > 0) return 1'b1;
        if (!dec_valid) return 1'b0;
        return pipe[d][0].v && pipe[d][0].ld && pipe[d][0].regw &&
               ((m_used(dec_use1, dec_Rs1) && pipe[d][0].rd == dec_Rs1) ||
                (m_used(dec_use2, dec_Rs2) && pipe[d][0].rd == dec_Rs2));
    endfunction

    function automatic logic [1:0] m_fwd(input int d, input logic u, input logic [4:0] r);
        if (!dec_valid || !m_used(u, r)) return 2'd0;
        for (int k = 0; k < 3; k++) begin
            if (pipe[d][k].v && pipe[d][k].regw && pipe[d][k].rd == r &&
                !(k == 0 && pipe[d][k].ld)) return 2'(k + 1);
        end
        return 2'd0;
    endfunction

    task automatic m_reset();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 3; k++) pipe[d][k] = '0;
            remain[d] = 0;
            scnt[d] = 0;
            fcnt[d] = 0;
        end
    endtask

    task automatic m_advance();
        logic st, fl;
        for (int d = 0; d < 2; d++) begin
            st = m_stall(d);
            fl = dec_valid && PC_Src != 2'b00 && !st;
            if (st) scnt[d]++;
            if (fl) fcnt[d]++;
            if (remain[d] > 0) remain[d]--;
            else if (st) remain[d] = lus[d] - 1;
            pipe[d][2] = pipe[d][1];
            pipe[d][1] = pipe[d][0];
            pipe[d][0] = (dec_valid && !st) ? ent_t'{1'b1, dec_Rd, dec_RegW, dec_mem_R} : '0;
        end
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic st, fl;
        logic [1:0] fa, fb;
        for (int d = 0; d < 2; d++) begin
            st = m_stall(d);
            fl = dec_valid && PC_Src != 2'b00 && !st;
            fa = m_fwd(d, dec_use1, dec_Rs1);
            fb = m_fwd(d, dec_use2, dec_Rs2);
            if (d == 0) begin
                chk({tag, "_a_ctl"}, {sf_a, sd_a, be_a, fl_a}, {st, st, st, fl});
                if (!st) chk({tag, "_a_fwd"}, {fa_a, fb_a}, {fa, fb});
                chk({tag, "_a_cnt"}, {sc_a, fc_a}, {CW_A'(scnt[0]), CW_A'(fcnt[0])});
            end else begin
                chk({tag, "_b_ctl"}, {sf_b, sd_b, be_b, fl_b}, {st, st, st, fl});
                if (!st) chk({tag, "_b_fwd"}, {fa_b, fb_b}, {fa, fb});
                chk({tag, "_b_scnt"}, 64'(sc_b), 64'(CW_B'(scnt[1])));
                chk({tag, "_b_fcnt"}, 64'(fc_b), 64'(CW_B'(fcnt[1])));
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    typedef struct {
        logic v; logic [4:0] rs1; logic u1; logic [4:0] rs2; logic u2;
        logic [4:0] rd; logic regw; logic ld; logic [1:0] pcs;
        logic e_st; logic e_fl; logic [1:0] e_fa; logic [1:0] e_fb; int e_sc; int e_fc;
    } vec_t;

    function automatic vec_t mk(input logic v, input int rs1, input logic u1, input int rs2,
                                input logic u2, input int rd, input logic regw, input logic ld,
                                input int pcs, input logic st, input logic fl, input int fa,
                                input int fb, input int sc, input int fc);
        vec_t r;
        r.v = v; r.rs1 = 5'(rs1); r.u1 = u1; r.rs2 = 5'(rs2); r.u2 = u2;
        r.rd = 5'(rd); r.regw = regw; r.ld = ld; r.pcs = 2'(pcs);
        r.e_st = st; r.e_fl = fl; r.e_fa = 2'(fa); r.e_fb = 2'(fb); r.e_sc = sc; r.e_fc = fc;
        return r;
    endfunction

    task automatic drive(input vec_t r);
        dec_valid = r.v; dec_Rs1 = r.rs1; dec_use1 = r.u1; dec_Rs2 = r.rs2; dec_use2 = r.u2;
        dec_Rd = r.rd; dec_RegW = r.regw; dec_mem_R = r.ld; PC_Src = r.pcs;
    endtask

    // Inputs are set just after a rising edge; outputs compared at the falling edge
    task automatic cycle(input string tag);
        @(negedge clk);
        check_model(tag);
        m_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_reset();
    endtask

    vec_t tbl [16];
    vec_t idle;
    vec_t lw7;
    vec_t use7;
    int n_st;
    logic done;
    logic [1:0] fb_end;

    initial begin
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        lw7  = mk(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        use7 = mk(1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // v rs1 u1 rs2 u2 rd regw ld pcs | st fl fa fb scnt fcnt   (LOAD_USE_STALLS=1)
        tbl[0]  = mk(1, 1, 1, 2, 1, 5, 1, 0, 0,  0, 0, 0, 0, 0, 0);  // ADD R5
        tbl[1]  = mk(1, 5, 1, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0);  // R5 from EX
        tbl[2]  = mk(1, 5, 1, 0, 0, 0, 0, 0, 0,  0, 0, 2, 0, 0, 0);  // from MEM
        tbl[3]  = mk(1, 5, 1, 0, 0, 0, 0, 0, 0,  0, 0, 3, 0, 0, 0);  // from WB
        tbl[4]  = mk(1, 5, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);  // retired
        tbl[5]  = mk(1, 0, 0, 0, 0, 7, 1, 1, 0,  0, 0, 0, 0, 0, 0);  // LW R7
        tbl[6]  = mk(1, 0, 0, 7, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0);  // load-use
        tbl[7]  = mk(1, 0, 0, 7, 1, 0, 0, 0, 0,  0, 0, 0, 2, 1, 0);  // re-presented
        tbl[8]  = mk(1, 0, 0, 0, 0, 0, 1, 1, 0,  0, 0, 0, 0, 1, 0);  // LW R0
        tbl[9]  = mk(1, 0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0);  // read R0
        tbl[10] = mk(1, 0, 0, 0, 0, 0, 0, 0, 1,  0, 1, 0, 0, 1, 0);  // JMP
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 1);
        tbl[12] = mk(1, 0, 0, 0, 0, 9, 1, 1, 0,  0, 0, 0, 0, 1, 1);  // LW R9
        tbl[13] = mk(1, 9, 1, 0, 0, 0, 0, 0, 2,  1, 0, 0, 0, 1, 1);  // JALR R9: stall wins
        tbl[14] = mk(1, 9, 1, 0, 0, 0, 0, 0, 2,  0, 1, 2, 0, 2, 1);  // re-presented: flush
        tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2, 2);

        m_reset();

        // Reset held with a live decode: every output stays low
        drive(mk(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("reset_out%0d", i),
                {sf_a, sd_a, be_a, fl_a, fa_a, fb_a, sc_a, fc_a,
                 sf_b, sd_b, be_b, fl_b, fa_b, fb_b}, 64'd0);
            chk($sformatf("reset_cnt_b%0d", i), {sc_b, fc_b}, 64'd0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        drive(idle);
        @(negedge clk);
        chk("post_reset_cnt", {sc_a, fc_a, sc_b, fc_b}, 64'd0);
        m_advance();
        @(posedge clk);
        #1;

        // Directed vectors
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i]);
            @(negedge clk);
            chk($sformatf("vec%0d_ctl", i), {sf_a, sd_a, be_a, fl_a},
                {tbl[i].e_st, tbl[i].e_st, tbl[i].e_st, tbl[i].e_fl});
            if (!tbl[i].e_st)
                chk($sformatf("vec%0d_fwd", i), {fa_a, fb_a}, {tbl[i].e_fa, tbl[i].e_fb});
            chk($sformatf("vec%0d_cnt", i), {sc_a, fc_a},
                {CW_A'(tbl[i].e_sc), CW_A'(tbl[i].e_fc)});
            check_model($sformatf("vec%0d", i));
            m_advance();
            @(posedge clk);
            #1;
        end

        // Three-bubble load-use on the second instance
        do_reset();
        drive(lw7);
        cycle("lus3_lw");
        drive(use7);
        n_st = 0;
        done = 1'b0;
        fb_end = 2'd3;
        for (int k = 0; k < 10 && !done; k++) begin
            @(negedge clk);
            if (sf_b && sd_b && be_b) n_st++;
            else begin
                done = 1'b1;
                fb_end = fb_b;
            end
            check_model("lus3");
            m_advance();
            @(posedge clk);
            #1;
        end
        chk("lus3_stall_cycles", 64'(n_st), 64'd3);
        chk("lus3_stall_cnt", 64'(sc_b), 64'd3);
        chk("lus3_fwdB_after", 64'(fb_end), 64'd0);

        // Asynchronous reset in the middle of the second stall cycle
        do_reset();
        drive(lw7);
        cycle("mid_lw");
        drive(use7);
        cycle("mid_stall1");
        #2;
        chk("midstall_pre", {sf_b, sd_b, be_b}, 64'h7);
        rst = 1'b1;
        #1;
        chk("midstall_out", {sf_b, sd_b, be_b}, 64'd0);
        chk("midstall_cnt", {sc_b, sc_a}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_reset();
        cycle("mid_after");

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 800; i++) begin
            dec_valid = ($urandom_range(0, 9) != 0);
            dec_Rs1   = 5'($urandom_range(0, 3));
            dec_Rs2   = 5'($urandom_range(0, 3));
            dec_use1  = 1'($urandom_range(0, 1));
            dec_use2  = 1'($urandom_range(0, 1));
            dec_Rd    = 5'($urandom_range(0, 3));
            dec_RegW  = ($urandom_range(0, 3) != 0);
            dec_mem_R = ($urandom_range(0, 2) == 0);
            PC_Src    = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            cycle("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
